// File: rtl/mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_pkg
// Description : Shared mode encodings and output-register state type for the
//               registered round-robin multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_rr_pkg;

   // Arbitration mode encodings as seen on the mode port
   localparam logic [1:0] MODE_FIXED = 2'b00;
   localparam logic [1:0] MODE_RR    = 2'b01;
   localparam logic [1:0] MODE_PRIO  = 2'b10;
   localparam logic [1:0] MODE_HOLD  = 2'b11;

   // One-entry output register occupancy
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Combinational grant selection for fixed, round-robin,
//               priority and hold modes. One grant index plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
   import mux_rr_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [1:0]          mode,
   input  logic [CHANNELS-1:0] in_valid,
   input  logic [SEL_W-1:0]    rr_ptr,
   input  logic [SEL_W-1:0]    fixed_sel,
   output logic [SEL_W-1:0]    grant,
   output logic                grant_valid
);

   localparam logic [SEL_W:0] c_channels = (SEL_W+1)'(CHANNELS);

   // Channel index visited at search offset k, starting from rr_ptr
   logic [SEL_W-1:0]    w_rot_idx [CHANNELS];
   logic [CHANNELS-1:0] w_rot_valid;
   // Per-channel match of fixed_sel; an out-of-range select matches nothing
   logic [CHANNELS-1:0] w_fixed_hit;

   generate
      for (genvar k = 0; k < CHANNELS; k++) begin : g_rot
         logic [SEL_W:0] w_sum;
         // rr_ptr is always below CHANNELS, so one conditional subtract wraps
         assign w_sum          = {1'b0, rr_ptr} + (SEL_W+1)'(k);
         assign w_rot_idx[k]   = (w_sum >= c_channels) ? SEL_W'(w_sum - c_channels)
                                                       : w_sum[SEL_W-1:0];
         assign w_rot_valid[k] = in_valid[w_rot_idx[k]];
         assign w_fixed_hit[k] = in_valid[k] && (fixed_sel == SEL_W'(k));
      end
   endgenerate

   // Pick the grant for the active mode; descending loops let the lowest match win
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      case (mode)
         MODE_FIXED: begin
            grant       = fixed_sel;
            grant_valid = |w_fixed_hit;
         end
         MODE_RR: begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
               if (w_rot_valid[k]) begin
                  grant       = w_rot_idx[k];
                  grant_valid = 1'b1;
               end
            end
         end
         MODE_PRIO: begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
               if (in_valid[k]) begin
                  grant       = SEL_W'(k);
                  grant_valid = 1'b1;
               end
            end
         end
         default: begin
            grant       = '0;
            grant_valid = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_reg
// Description : Registered N-channel W-bit multiplexer with valid/ready
//               handshakes, selectable arbitration and a one-entry output
//               register supporting back-to-back transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_reg
   import mux_rr_pkg::*;
#(
   parameter  int BITS     = 3,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [CHANNELS*BITS-1:0] in_data,
   input  logic [CHANNELS-1:0]      in_valid,
   output logic [CHANNELS-1:0]      in_ready,
   input  logic [1:0]               mode,
   input  logic [SEL_W-1:0]         fixed_sel,
   output logic [BITS-1:0]          out_data,
   output logic [SEL_W-1:0]         out_sel,
   output logic                     out_valid,
   input  logic                     out_ready
);

   out_state_t       r_state;
   logic [BITS-1:0]  r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic [SEL_W-1:0] r_rr_ptr;

   logic [BITS-1:0]  w_chan_data [CHANNELS];
   logic [SEL_W-1:0] w_grant;
   logic             w_grant_valid;
   logic             w_load_en;
   logic             w_load;
   logic             w_accept;
   logic [SEL_W-1:0] w_ptr_next;

   mux_rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_arbiter (
      .mode        (mode),
      .in_valid    (in_valid),
      .rr_ptr      (r_rr_ptr),
      .fixed_sel   (fixed_sel),
      .grant       (w_grant),
      .grant_valid (w_grant_valid)
   );

   // The register can take a word when empty or when its word leaves this cycle
   assign w_load_en  = (r_state == ST_EMPTY) || out_ready;
   assign w_load     = w_load_en && w_grant_valid;
   // Handshake is suppressed while reset is held so no producer sees a false accept
   assign w_accept   = reset && w_load;
   assign w_ptr_next = (w_grant == SEL_W'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
         assign w_chan_data[i] = in_data[i*BITS +: BITS];
         assign in_ready[i]    = w_accept && (w_grant == SEL_W'(i));
      end
   endgenerate

   // Output register occupancy, captured word and round-robin pointer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_EMPTY;
         r_out_data <= '0;
         r_out_sel  <= '0;
         r_rr_ptr   <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_load) begin
                  r_state    <= ST_FULL;
                  r_out_data <= w_chan_data[w_grant];
                  r_out_sel  <= w_grant;
                  r_rr_ptr   <= w_ptr_next;
               end
            end
            ST_FULL: begin
               if (w_load) begin
                  r_state    <= ST_FULL;
                  r_out_data <= w_chan_data[w_grant];
                  r_out_sel  <= w_grant;
                  r_rr_ptr   <= w_ptr_next;
               end else if (out_ready) begin
                  r_state    <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_valid = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_reg
// Description : Self-checking bench for mux_rr_reg (BITS=3, CHANNELS=4) with
//               a reference model and a scoreboard of accepted words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_reg;

   localparam int BITS     = 3;
   localparam int CHANNELS = 4;
   localparam int SEL_W    = 2;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic [CHANNELS*BITS-1:0] in_data;
   logic [CHANNELS-1:0]      in_valid;
   logic [CHANNELS-1:0]      in_ready;
   logic [1:0]               mode;
   logic [SEL_W-1:0]         fixed_sel;
   logic [BITS-1:0]          out_data;
   logic [SEL_W-1:0]         out_sel;
   logic                     out_valid;
   logic                     out_ready;

   typedef struct packed {
      logic [BITS-1:0]  d;
      logic [SEL_W-1:0] s;
   } word_t;

   word_t            sb_q [$];
   int               n_cmp = 0;
   int               n_bad = 0;
   logic             m_valid;
   logic [SEL_W-1:0] m_ptr;
   word_t            m_word;

   mux_rr_reg #(
      .BITS     (BITS),
      .CHANNELS (CHANNELS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .fixed_sel (fixed_sel),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clock = ~clock;

   task automatic set_chan(input int ch, input logic [BITS-1:0] d);
      in_data[ch*BITS +: BITS] = d;
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_ptr   = '0;
      m_word  = '0;
      sb_q.delete();
   endtask

   // Reference arbiter: 00 fixed, 01 round robin, 10 lowest index, 11 none
   task automatic model_grant(output logic gv, output logic [SEL_W-1:0] g);
      int idx;
      gv = 1'b0;
      g  = '0;
      case (mode)
         2'b00: begin
            if (in_valid[fixed_sel]) begin
               gv = 1'b1;
               g  = fixed_sel;
            end
         end
         2'b01: begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
               idx = (int'(m_ptr) + k) % CHANNELS;
               if (in_valid[idx]) begin
                  gv = 1'b1;
                  g  = idx[SEL_W-1:0];
               end
            end
         end
         2'b10: begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
               if (in_valid[k]) begin
                  gv = 1'b1;
                  g  = k[SEL_W-1:0];
               end
            end
         end
         default: gv = 1'b0;
      endcase
   endtask

   // One clock of scoreboard traffic with the currently driven inputs
   task automatic tick();
      logic             gv;
      logic [SEL_W-1:0] g;
      logic             load;
      logic [CHANNELS-1:0] exp_rdy;
      word_t            w;
      @(negedge clock);
      model_grant(gv, g);
      load    = (!m_valid || out_ready) && gv;
      exp_rdy = '0;
      if (load) exp_rdy[g] = 1'b1;
      n_cmp++;
      if (in_ready !== exp_rdy) begin
         n_bad++;
         $display("FAIL sb_in_ready: got %b expected %b", in_ready, exp_rdy);
      end
      if (load) begin
         w.d = in_data[g*BITS +: BITS];
         w.s = g;
         sb_q.push_back(w);
         m_ptr = g + 2'd1;
         if (g == SEL_W'(CHANNELS - 1)) m_ptr = '0;
      end
      @(posedge clock);
      #1;
      if (load) begin
         m_word  = sb_q.pop_front();
         m_valid = 1'b1;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      n_cmp++;
      if (out_valid !== m_valid) begin
         n_bad++;
         $display("FAIL sb_out_valid: got %b expected %b", out_valid, m_valid);
      end
      if (m_valid) begin
         n_cmp++;
         if (out_data !== m_word.d || out_sel !== m_word.s) begin
            n_bad++;
            $display("FAIL sb_word: got data %b sel %0d expected data %b sel %0d",
                     out_data, out_sel, m_word.d, m_word.s);
         end
      end
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         in_valid  = 4'($urandom_range(0, 15));
         in_data   = 12'($urandom_range(0, 4095));
         mode      = 2'($urandom_range(0, 3));
         fixed_sel = 2'($urandom_range(0, 3));
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         n_cmp++;
         if (out_valid !== 1'b0 || out_data !== 3'b000 || out_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid %b data %b sel %0d expected 0 0 0",
                     out_valid, out_data, out_sel);
         end
         n_cmp++;
         if (in_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
         end
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      mode      = 2'b10;
      in_valid  = 4'b0100;
      in_data   = '0;
      set_chan(2, 3'b101);
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if (out_data !== 3'b101 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_first_load: got data %b sel %0d expected 101 sel 2",
                  out_data, out_sel);
      end
   endtask

   task automatic test_rr_fairness();
      int exp_sel [5];
      int hits [CHANNELS];
      exp_sel = '{0, 1, 2, 3, 0};
      for (int i = 0; i < CHANNELS; i++) hits[i] = 0;
      // Load from channel 3 first so the pointer wraps to 0
      mode     = 2'b10;
      in_valid = 4'b1000;
      tick();
      mode = 2'b01;
      in_valid = 4'b1111;
      for (int i = 0; i < CHANNELS; i++) set_chan(i, 3'(i + 4));
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (int'(out_sel) !== exp_sel[c]) begin
            n_bad++;
            $display("FAIL rr_sequence[%0d]: got sel %0d expected %0d", c, out_sel, exp_sel[c]);
         end
         if (c < 4) begin
            for (int i = 0; i < CHANNELS; i++) hits[i] += int'(in_ready[i]);
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         n_cmp++;
         if (hits[i] !== 1) begin
            n_bad++;
            $display("FAIL rr_ready_count[%0d]: got %0d expected 1", i, hits[i]);
         end
      end
   endtask

   task automatic test_fixed();
      mode      = 2'b00;
      fixed_sel = 2'd3;
      in_valid  = 4'b1000;
      set_chan(3, 3'b011);
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if (out_data !== 3'b011 || out_sel !== 2'd3) begin
         n_bad++;
         $display("FAIL fixed_load: got data %b sel %0d expected 011 sel 3", out_data, out_sel);
      end
      in_valid = 4'b0111;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
         n_bad++;
         $display("FAIL fixed_no_load: got valid %b ready %b expected 0 0000", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      mode      = 2'b10;
      in_valid  = 4'b0001;
      set_chan(0, 3'b110);
      out_ready = 1'b1;
      tick();
      set_chan(0, 3'b001);
      set_chan(1, 3'b010);
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (in_ready !== 4'b0000 || out_data !== 3'b110 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stall[%0d]: got ready %b data %b valid %b expected 0000 110 1",
                     c, in_ready, out_data, out_valid);
         end
      end
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if (out_data !== 3'b001 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_release: got data %b valid %b expected 001 1", out_data, out_valid);
      end
   endtask

   task automatic test_hold_drain();
      mode      = 2'b11;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_drain: got valid %b expected 0", out_valid);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_idle[%0d]: got ready %b valid %b expected 0000 0",
                     c, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_reset_midstream();
      // Loading channel 1 leaves the pointer at 2 with the register full
      mode      = 2'b10;
      in_valid  = 4'b0010;
      set_chan(1, 3'b111);
      out_ready = 1'b1;
      tick();
      mode     = 2'b01;
      in_valid = 4'b1111;
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
         n_bad++;
         $display("FAIL midreset_clear: got valid %b ready %b expected 0 0000", out_valid, in_ready);
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();
      tick();
      n_cmp++;
      if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset_first_sel: got sel %0d valid %b expected 0 1", out_sel, out_valid);
      end
   endtask

   initial begin
      in_data   = '0;
      in_valid  = '0;
      mode      = 2'b00;
      fixed_sel = '0;
      out_ready = 1'b0;
      model_reset();
      #2;
      reset = 1'b0;
      test_reset();
      test_rr_fairness();
      test_fixed();
      test_backpressure();
      test_hold_drain();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
